// File: rtl/echo_fb_delay_pkg.sv
// Shared definitions for the feedback echo: default widths, Q-format gain
// constants, FSM state encoding and a generic saturating narrow helper.
package echo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_COEF_W = 16;

  localparam int Q_UNITY = (32'sd1 <<< (DEF_COEF_W - 1)) - 32'sd1;
  localparam int Q_HALF  = 32'sd1 <<< (DEF_COEF_W - 2);

  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // v holds an in_w-bit signed value right-aligned; result is clamped to the
  // out_w-bit signed range and returned sign-extended to SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_s(
    input logic signed [SAT_W-1:0] v,
    input int                      in_w,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] ext;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    ext = (v <<< (SAT_W - in_w)) >>> (SAT_W - in_w);
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    if (ext > hi) begin
      sat_s = hi;
    end else if (ext < lo) begin
      sat_s = lo;
    end else begin
      sat_s = ext;
    end
  endfunction

endpackage

// File: rtl/echo_fb_delay_if.sv
// Sample/control bundle between the codec path and the echo block.
interface echo_fb_delay_if
  import echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COEF_W = DEF_COEF_W
) ();

  logic                     clk_enable;
  logic [ADDR_W-1:0]        delay;
  logic signed [COEF_W-1:0] fb_gain;
  logic signed [COEF_W-1:0] mix_gain;
  logic signed [DATA_W-1:0] audio_in;
  logic signed [DATA_W-1:0] audio_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport slave (
    input  clk_enable, delay, fb_gain, mix_gain, audio_in,
    output audio_out, out_valid, busy, overrun
  );

  modport master (
    output clk_enable, delay, fb_gain, mix_gain, audio_in,
    input  audio_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/echo_fb_delay_ram.sv
// Single-port delay line storage with registered read; no reset on the array
// so it maps onto block RAM.
module echo_delay_ram
  import echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/echo_fb_delay.sv
// Recirculating echo: circular delay RAM with programmable tap, feedback and
// wet mix, saturating arithmetic, post-reset RAM clear and overrun reporting.
module echo_fb_delay
  import echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input logic            clk,
  input logic            reset,
  echo_fb_delay_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = DATA_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_W-1:0]        r_wptr;
  logic [ADDR_W-1:0]        r_clr_addr;
  logic [ADDR_W-1:0]        r_delay;
  logic signed [COEF_W-1:0] r_fb_gain;
  logic signed [COEF_W-1:0] r_mix_gain;
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_w;
  logic signed [DATA_W-1:0] r_audio_out;
  logic                     r_out_valid;
  logic                     r_overrun;
  logic                     r_busy;

  logic                     w_accept;
  logic                     w_drop;
  logic                     w_ram_we;
  logic                     w_ram_re;
  logic [ADDR_W-1:0]        w_ram_addr;
  logic [DATA_W-1:0]        w_ram_wdata;
  logic [DATA_W-1:0]        w_ram_rdata;

  logic signed [DATA_W-1:0] w_d;
  logic signed [PROD_W-1:0] w_fb_prod;
  logic signed [PROD_W-1:0] w_mix_prod;
  logic signed [SUM_W-1:0]  w_w_sum;
  logic signed [SUM_W-1:0]  w_y_sum;
  logic signed [DATA_W-1:0] w_w_sat;
  logic signed [DATA_W-1:0] w_y_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobes are only accepted in IDLE; any other state drops them.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_wptr;
    w_ram_wdata = {DATA_W{1'b0}};
    case (r_state)
      ST_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
        w_drop     = bus.clk_enable;
        if (r_clr_addr == ADDR_MAX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        w_ram_addr = r_wptr - bus.delay;
        if (bus.clk_enable) begin
          w_accept    = 1'b1;
          w_ram_re    = 1'b1;
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        w_drop      = bus.clk_enable;
        w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        w_drop      = bus.clk_enable;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = r_w;
        w_drop      = bus.clk_enable;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_drop      = bus.clk_enable;
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Full-width products, floor shift back to sample scale, 1-bit-wider sums.
  always_comb begin
    w_d        = (r_delay == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : $signed(w_ram_rdata);
    w_fb_prod  = PROD_W'(r_fb_gain) * PROD_W'(w_d);
    w_mix_prod = PROD_W'(r_mix_gain) * PROD_W'(w_d);
    w_w_sum    = SUM_W'(r_x) + SUM_W'(w_fb_prod >>> (COEF_W - 1));
    w_y_sum    = SUM_W'(r_x) + SUM_W'(w_mix_prod >>> (COEF_W - 1));
    w_w_sat    = DATA_W'(sat_s(SAT_W'(w_w_sum), SUM_W, DATA_W));
    w_y_sat    = DATA_W'(sat_s(SAT_W'(w_y_sum), SUM_W, DATA_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= {ADDR_W{1'b0}};
      r_clr_addr  <= {ADDR_W{1'b0}};
      r_delay     <= {ADDR_W{1'b0}};
      r_fb_gain   <= {COEF_W{1'b0}};
      r_mix_gain  <= {COEF_W{1'b0}};
      r_x         <= {DATA_W{1'b0}};
      r_w         <= {DATA_W{1'b0}};
      r_audio_out <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= w_drop;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR_ONE;
      end
      if (w_accept) begin
        r_x        <= bus.audio_in;
        r_delay    <= bus.delay;
        r_fb_gain  <= bus.fb_gain;
        r_mix_gain <= bus.mix_gain;
      end
      // Output is published from the MAC edge so it is visible during WRITE.
      if (r_state == ST_MAC) begin
        r_w         <= w_w_sat;
        r_audio_out <= w_y_sat;
        r_out_valid <= 1'b1;
      end
      if (r_state == ST_WRITE) begin
        r_wptr <= r_wptr + ADDR_ONE;
      end
    end
  end

  echo_delay_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign bus.audio_out = r_audio_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_echo_fb_delay.sv
// Scoreboard bench for echo_fb_delay: stimulus pushes expected outputs and
// overrun pulses with their due cycle; a negedge monitor pops and compares.
module tb_echo_fb_delay;
  import echo_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int COEF_W = 16;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_y = 0;
  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  echo_fb_delay_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) bus ();

  echo_fb_delay #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due < cyc && !bus.out_valid) begin
      check("out_missing", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_spurious", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_cycle", cyc, mon_e.due);
        check("out_value", int'(bus.audio_out), mon_e.val);
        last_y = mon_e.val;
      end
    end else begin
      check("out_hold", int'(bus.audio_out), last_y);
    end
    if (ovr_q.size() > 0 && ovr_q[0] < cyc && !bus.overrun) begin
      check("overrun_missing", cyc, ovr_q[0]);
      void'(ovr_q.pop_front());
    end
    if (bus.overrun) begin
      if (ovr_q.size() == 0) begin
        check("overrun_spurious", 1, 0);
      end else begin
        check("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  task automatic set_cfg(input int d, input int fb, input int mix);
    bus.delay    = ADDR_W'(d);
    bus.fb_gain  = COEF_W'(fb);
    bus.mix_gain = COEF_W'(mix);
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    bus.audio_in   = DATA_W'(x);
    bus.clk_enable = 1'b1;
    exp_q.push_back('{val: y, due: cyc + 3});
    @(negedge clk);
    bus.clk_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_dut(input bit with_drops);
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_audio_out", int'(bus.audio_out), 0);
    last_y = 0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      bus.clk_enable = with_drops && (n == 100 || n == 600);
      if (bus.clk_enable) ovr_q.push_back(cyc + 1);
      @(negedge clk);
      n++;
    end
    bus.clk_enable = 1'b0;
    check("busy_cycles", n, 1024);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.clk_enable = 1'b0;
    bus.audio_in   = '0;
    set_cfg(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", int'(bus.busy), 1);
    check("init_out_valid", int'(bus.out_valid), 0);
    check("init_audio_out", int'(bus.audio_out), 0);

    // Impulse, no feedback; strobes during the clear sweep are dropped.
    reset_dut(1'b1);
    set_cfg(4, 0, Q_HALF);
    send(16000, 16000);
    for (int i = 1; i < 8; i++) send(0, (i == 4) ? 8000 : 0);

    // Feedback decay.
    reset_dut(1'b0);
    set_cfg(2, Q_HALF, Q_HALF);
    send(16000, 16000);
    for (int i = 1; i < 8; i++) send(0, (i == 2) ? 8000 : (i == 4) ? 4000 : (i == 6) ? 2000 : 0);

    // Output saturation both ways, then floor rounding of a negative product.
    reset_dut(1'b0);
    set_cfg(1, 0, Q_UNITY);
    send(30000, 30000);
    send(30000, 32767);
    send(30000, 32767);
    send(-30000, -1);
    send(-30000, -32768);
    send(-30000, -32768);
    set_cfg(1, 0, Q_HALF);
    send(-3, -15003);
    send(0, -2);

    // Buffer write saturation seen through the wet path.
    set_cfg(1, Q_UNITY, Q_HALF);
    send(30000, 30000);
    send(30000, 32767);
    send(0, 16383);
    send(0, 16383);

    // D=0 mutes the tap but the buffer is still written.
    set_cfg(0, 0, Q_UNITY);
    send(5000, 5000);
    send(5000, 5000);
    set_cfg(1, 0, Q_UNITY);
    send(0, 4999);

    // Strobe 2 cycles after an accepted one is dropped without side effects.
    set_cfg(1, 0, Q_HALF);
    @(negedge clk);
    bus.audio_in   = DATA_W'(1000);
    bus.clk_enable = 1'b1;
    exp_q.push_back('{val: 1000, due: cyc + 3});
    @(negedge clk);
    bus.clk_enable = 1'b0;
    @(negedge clk);
    bus.audio_in   = DATA_W'(20000);
    bus.clk_enable = 1'b1;
    ovr_q.push_back(cyc + 1);
    @(negedge clk);
    bus.clk_enable = 1'b0;
    send(0, 500);
    send(0, 0);

    // Maximum delay with the write pointer crossing the end of the RAM.
    reset_dut(1'b0);
    set_cfg(1023, 0, Q_UNITY);
    for (int i = 0; i < 10; i++) send(0, 0);
    send(1000, 1000);
    for (int i = 1; i <= 1024; i++) send(0, (i == 1023) ? 999 : 0);

    // Reset with an echo pending and a sample in flight leaves nothing behind.
    reset_dut(1'b0);
    set_cfg(4, Q_HALF, Q_HALF);
    send(16000, 16000);
    send(0, 0);
    @(negedge clk);
    bus.audio_in   = DATA_W'(7000);
    bus.clk_enable = 1'b1;
    @(negedge clk);
    bus.clk_enable = 1'b0;
    reset_dut(1'b0);
    for (int i = 0; i < 8; i++) send(0, 0);

    repeat (6) @(negedge clk);
    check("out_queue_empty", exp_q.size(), 0);
    check("overrun_queue_empty", ovr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/echo_fb_delay.md
# echo_fb_delay

Parametrised feedback echo for the audio loopback effects chain: one signed sample per `clk_enable` strobe, stored in a circular delay RAM with programmable tap and feedback, mixed with the dry input and saturated to output width. It extends the fixed single-tap echo with the following:
- parametrised width, depth and coefficient format
- recirculating (IIR) feedback
- saturation instead of wrap
- RAM clear sweep after reset
- an overrun flag

It sits between the codec RX deserialiser and the TX serialiser in place of the fixed echo.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `ADDR_W`, 10: delay RAM address width. Depth is 2^ADDR_W samples.
- `COEF_W`, 16: gain width, signed Q1.(COEF_W-1).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: one-cycle sample strobe.
- `delay` in ADDR_W: echo delay D in samples. 0 disables the echo.
- `fb_gain` in COEF_W: feedback gain into the buffer.
- `mix_gain` in COEF_W: wet gain into the output.
- `audio_in` in DATA_W: input sample, sampled on a strobe.
- `audio_out` out DATA_W: output sample, registered.
- `out_valid` out 1: one-cycle pulse when `audio_out` updates.
- `busy` out 1: high during the clear sweep and while a sample is being processed.
- `overrun` out 1: one-cycle pulse when a strobe is dropped.

## Operation
- Recurrence per sample n, where d[n] = w[n-D] for D≥1 and d[n] = 0 for D=0:
  - w[n] = sat(x[n] + (fb_gain·d[n] >>> (COEF_W-1)))
  - y[n] = sat(x[n] + (mix_gain·d[n] >>> (COEF_W-1)))
- The buffer is always written, including when D=0.
- Arithmetic rules:
  - Products are full width, DATA_W+COEF_W signed.
  - Products are arithmetic-shifted right, which truncates toward -inf.
  - Sums are computed in DATA_W+1 bits.
  - Results are saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. No wrap anywhere.
- Pointers:
  - Write pointer `wptr` is ADDR_W bits and wraps modulo depth.
  - Read address = `wptr - delay` modulo depth.
  - `delay`, `fb_gain` and `mix_gain` are captured on the strobe. Changes between strobes take effect on the next sample.
- State machine (`CLEAR`, `IDLE`, `READ`, `MAC`, `WRITE`):
  - `CLEAR`: writes 0 to every address, 2^ADDR_W cycles, then goes to `IDLE`.
  - `IDLE`: on `clk_enable`, latches the input and coefficients, issues the RAM read, then goes to `READ`.
  - `READ`: the RAM output register becomes valid; goes to `MAC`.
  - `MAC`: computes and registers w and y; goes to `WRITE`.
  - `WRITE`: writes w at `wptr`, increments `wptr`, updates `audio_out`, pulses `out_valid`, returns to `IDLE`.
- Strobe outside `IDLE`, including during `CLEAR`:
  - The sample is dropped and `overrun` pulses the next cycle.
  - State, pointer and outputs are unaffected.
- Reset (also mid-sample or mid-sweep):
  - Applied next edge: `wptr`=0, `audio_out`=0, `out_valid`=0, `overrun`=0, `busy`=1.
  - State goes to `CLEAR`, which restarts from address 0.
  - Any in-flight sample is discarded.

## Timing
- Strobe in cycle k → `out_valid` high and new `audio_out` in cycle k+3. Fixed 3-cycle latency.
- Minimum strobe spacing is 4 cycles. Back-to-back strobes at spacing 4 are all accepted.
- `busy`:
  - High from reset until 2^ADDR_W cycles after reset deassertion.
  - High in `READ`, `MAC` and `WRITE`.
- The RAM is single-port with synchronous read (1-cycle latency), so read and write never collide.
- `audio_out` holds its value between `out_valid` pulses.

## Structure
- Package `echo_pkg`:
  - Q-format constants: unity = 2^(COEF_W-1)-1, half = 2^(COEF_W-2).
  - State enum.
  - A saturation function parametrised on input and output widths.
- Sub-module `echo_delay_ram`: single-port synchronous RAM, DATA_W × 2^ADDR_W, mapped to block RAM.
- The top level holds the FSM, pointers, MAC and saturation.

## Test plan
- Impulse, fb=0: D=4, fb=0, mix=0x4000. Input 16000 then zeros → out 16000 at n=0, 8000 at n=4, 0 elsewhere, each 3 cycles after its strobe.
- Feedback decay: D=2, fb=0x4000, mix=0x4000. Impulse 16000 → out 16000 at n=0, 8000 at n=2, 4000 at n=4, 2000 at n=6.
- Saturation: D=1, mix=0x7FFF, fb=0.
  - Constant 30000 → out 32767 from n=1.
  - Constant -30000 → out -32768.
  - No wrap in either case.
- Wrap/max delay (ADDR_W=10): D=1023, impulse 1000, mix=0x7FFF, fb=0 → 999 at n=1023. `wptr` wraps correctly across the end of the RAM.
- Overrun and clear:
  - Strobe 2 cycles after an accepted strobe → `overrun` pulse, sample dropped, the next valid output unchanged.
  - Strobes during `CLEAR` → dropped with `overrun`.
- Reset mid-echo: impulse, then reset before the echo is due → `busy` for 1024 cycles. After the sweep, with zero input, outputs are 0 and no residual echo appears.
